// File: rtl/adder_pkg.sv
// Shared definitions for the chunked wide-adder sequencer: state encoding and
// default operand/chunk widths.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 128;
  localparam int DEFAULT_CHUNK = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Operand and result handshakes of the chunked adder sequencer; the master is
// the producer/consumer side, the slave is the sequencer.
interface adder_seq_ctrl_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/adder_seq_ctrl_chunk_adder.sv
// Combinational CHUNK-bit adder with carry in/out; the one narrow adder that the
// sequencer time-shares across all chunks.
module chunk_adder
  import adder_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             ci_i,
  output logic [CHUNK-1:0] s_o,
  output logic             co_o
);

  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, ci_i};

endmodule

// File: rtl/adder_seq.sv
// Multi-cycle WIDTH-bit adder: latches one operand pair, adds CHUNK bits per
// cycle with a registered carry, then holds the result until it is taken.
module adder_seq_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input logic            clk,
  input logic            clr,
  adder_seq_ctrl_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("adder_seq_ctrl: WIDTH must be a multiple of CHUNK");
  end

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       carry_q, carry_d;
  logic                       cout_q, cout_d;
  logic [N-1:0][CHUNK-1:0]    a_q, a_d;
  logic [N-1:0][CHUNK-1:0]    b_q, b_d;
  logic [N-1:0][CHUNK-1:0]    sum_q, sum_d;
  logic [CHUNK-1:0]           s_chunk;
  logic                       c_chunk;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a_i  (a_q[cnt_q]),
    .b_i  (b_q[cnt_q]),
    .ci_i (carry_q),
    .s_o  (s_chunk),
    .co_o (c_chunk)
  );

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[cnt_q] = s_chunk;
        carry_d      = c_chunk;
        // The counter parks on the last chunk instead of wrapping; accept reloads it.
        if (cnt_q == LAST) begin
          cout_d  = c_chunk;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      // NOTE: the wide operand/sum registers are reset as well, because an abort
      // must leave sum/cout at known zero rather than a stale partial result.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  // in_ready is gated by clr so nothing is offered while reset is held.
  assign bus.in_ready  = (state_q == ST_IDLE) && !clr;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl: a transaction-level model (edges since
// accept, expected a+b+cin) is compared against the default DUT every cycle.
module tb_adder_seq_ctrl;

  localparam int W      = 128;
  localparam int N_MAIN = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  adder_seq_ctrl_if #(.WIDTH(W)) bus   ();
  adder_seq_ctrl_if #(.WIDTH(W)) bus1  ();
  adder_seq_ctrl_if #(.WIDTH(W)) bus16 ();

  adder_seq_ctrl #(.WIDTH(W), .CHUNK(32))  dut   (.clk(clk), .clr(clr), .bus(bus));
  adder_seq_ctrl #(.WIDTH(W), .CHUNK(128)) dut1  (.clk(clk), .clr(clr), .bus(bus1));
  adder_seq_ctrl #(.WIDTH(W), .CHUNK(8))   dut16 (.clk(clk), .clr(clr), .bus(bus16));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: age = edges since the accepted op (-1 = no op in flight).
  int         age = -1;
  logic [W:0] exp_res = '0;
  int         n_acc = 0;
  int         n_deliv = 0;
  int         cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      age <= -1;
    end else if (age < 0) begin
      if (bus.in_valid) begin
        age     <= 0;
        exp_res <= {1'b0, bus.a} + {1'b0, bus.b} + (W + 1)'(bus.cin);
        n_acc   <= n_acc + 1;
      end
    end else if (age < N_MAIN) begin
      age <= age + 1;
    end else if (bus.out_ready) begin
      age     <= -1;
      n_deliv <= n_deliv + 1;
    end
  end

  always @(negedge clk) begin
    check("in_ready",  (W + 1)'(bus.in_ready),  (W + 1)'(!clr && age < 0));
    check("out_valid", (W + 1)'(bus.out_valid), (W + 1)'(age >= N_MAIN));
    check("busy",      (W + 1)'(bus.busy),      (W + 1)'(age >= 0));
    if (age >= N_MAIN) begin
      check("sum",  (W + 1)'(bus.sum),  (W + 1)'(exp_res[W-1:0]));
      check("cout", (W + 1)'(bus.cout), (W + 1)'(exp_res[W]));
    end
  end

  // All driving tasks start and end #1 after a rising edge.
  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int g = 0;
    bus.a = a; bus.b = b; bus.cin = c; bus.in_valid = 1'b1;
    while (!bus.in_ready && g < 50) begin @(posedge clk); #1; g++; end
    if (g >= 50) check("accept_timeout", (W + 1)'(bus.in_ready), (W + 1)'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = rand128(); bus.b = rand128(); bus.cin = 1'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (lat >= 200) check("result_timeout", (W + 1)'(bus.out_valid), (W + 1)'(1));
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic sweep(input bit n1, input int exp_lat, input string tag);
    int lat = 0;
    if (n1) begin bus1.a = '1; bus1.b = '0; bus1.cin = 1'b1; bus1.in_valid = 1'b1; end
    else    begin bus16.a = '1; bus16.b = '0; bus16.cin = 1'b1; bus16.in_valid = 1'b1; end
    check({tag, "_in_ready"}, (W + 1)'(n1 ? bus1.in_ready : bus16.in_ready), (W + 1)'(1));
    @(posedge clk); #1;
    bus1.in_valid = 1'b0; bus16.in_valid = 1'b0;
    while (!(n1 ? bus1.out_valid : bus16.out_valid) && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, (W + 1)'(lat), (W + 1)'(exp_lat));
    check({tag, "_sum"},  (W + 1)'(n1 ? bus1.sum : bus16.sum),   (W + 1)'(0));
    check({tag, "_cout"}, (W + 1)'(n1 ? bus1.cout : bus16.cout), (W + 1)'(1));
    bus1.out_ready = n1; bus16.out_ready = !n1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0; bus16.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int acc0, del0, idx, n_out;
    int out_t [3];
    bit acc, deliv, seen;
    logic [W-1:0] ra [3];
    logic [W-1:0] rb [3];
    logic         rc [3];
    logic [W-1:0] pa, pb;
    logic         pc;
    logic [W:0]   pexp;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;

    // Reset state, in_ready held low while clr is asserted
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  (W + 1)'(bus.in_ready),  (W + 1)'(0));
    check("rst_out_valid", (W + 1)'(bus.out_valid), (W + 1)'(0));
    check("rst_busy",      (W + 1)'(bus.busy),      (W + 1)'(0));
    check("rst_sum",       (W + 1)'(bus.sum),       (W + 1)'(0));
    check("rst_cout",      (W + 1)'(bus.cout),      (W + 1)'(0));
    clr = 1'b0;
    #1;
    check("idle_in_ready", (W + 1)'(bus.in_ready), (W + 1)'(1));
    @(posedge clk); #1;

    // Carry ripples through every chunk
    accept_op('1, '0, 1'b1);
    wait_result(lat);
    check("ripple_latency", (W + 1)'(lat), (W + 1)'(N_MAIN));
    check("ripple_sum",  (W + 1)'(bus.sum),  (W + 1)'(0));
    check("ripple_cout", (W + 1)'(bus.cout), (W + 1)'(1));
    release_result();

    // Plain adds, including carry out of chunk 0 into chunk 1
    accept_op(128'h1, 128'h2, 1'b0);
    wait_result(lat);
    check("plain_sum",  (W + 1)'(bus.sum),  129'h3);
    check("plain_cout", (W + 1)'(bus.cout), (W + 1)'(0));
    release_result();
    accept_op(128'hFFFF_FFFF, 128'h1, 1'b0);
    wait_result(lat);
    check("chunk1_carry_sum", (W + 1)'(bus.sum), 129'h1_0000_0000);
    release_result();

    // Backpressure: result held stable for 10 cycles
    pa = rand128(); pb = rand128(); pc = 1'b1;
    pexp = {1'b0, pa} + {1'b0, pb} + (W + 1)'(pc);
    accept_op(pa, pb, pc);
    wait_result(lat);
    for (int i = 0; i < 10; i++) begin
      check("bp_sum",      (W + 1)'(bus.sum),      (W + 1)'(pexp[W-1:0]));
      check("bp_cout",     (W + 1)'(bus.cout),     (W + 1)'(pexp[W]));
      check("bp_in_ready", (W + 1)'(bus.in_ready), (W + 1)'(0));
      check("bp_busy",     (W + 1)'(bus.busy),     (W + 1)'(1));
      @(posedge clk); #1;
    end
    release_result();
    check("bp_release_in_ready",  (W + 1)'(bus.in_ready),  (W + 1)'(1));
    check("bp_release_out_valid", (W + 1)'(bus.out_valid), (W + 1)'(0));

    // Random ops with random consumer delay
    for (int t = 0; t < 4; t++) begin
      accept_op(rand128(), rand128(), 1'($urandom));
      wait_result(lat);
      check("rand_latency", (W + 1)'(lat), (W + 1)'(N_MAIN));
      repeat ($urandom_range(3)) begin @(posedge clk); #1; end
      release_result();
    end

    // Back-to-back with in_valid and out_ready held high
    for (int i = 0; i < 3; i++) begin ra[i] = rand128(); rb[i] = rand128(); rc[i] = 1'($urandom); end
    acc0 = n_acc; del0 = n_deliv; idx = 0; n_out = 0;
    bus.a = ra[0]; bus.b = rb[0]; bus.cin = rc[0];
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && n_out < 3; cyc++) begin
      @(negedge clk);
      acc   = bus.in_ready && bus.in_valid;
      deliv = bus.out_valid && bus.out_ready;
      @(posedge clk); #1;
      if (deliv) begin out_t[n_out] = cycle; n_out++; end
      if (acc) begin
        idx++;
        if (idx < 3) begin bus.a = ra[idx]; bus.b = rb[idx]; bus.cin = rc[idx]; end
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("b2b_results", (W + 1)'(n_out), (W + 1)'(3));
    check("b2b_accepts", (W + 1)'(n_acc - acc0), (W + 1)'(3));
    check("b2b_delivered", (W + 1)'(n_deliv - del0), (W + 1)'(3));
    if (n_out == 3) begin
      check("b2b_gap01", (W + 1)'(out_t[1] - out_t[0]), (W + 1)'(N_MAIN + 2));
      check("b2b_gap12", (W + 1)'(out_t[2] - out_t[1]), (W + 1)'(N_MAIN + 2));
    end

    // Reset mid-operation at RUN chunk k=2
    @(posedge clk); #1;
    accept_op(rand128(), rand128(), 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    clr = 1'b1;
    #1;
    check("abort_in_ready",  (W + 1)'(bus.in_ready),  (W + 1)'(0));
    check("abort_out_valid", (W + 1)'(bus.out_valid), (W + 1)'(0));
    check("abort_busy",      (W + 1)'(bus.busy),      (W + 1)'(0));
    check("abort_sum",       (W + 1)'(bus.sum),       (W + 1)'(0));
    check("abort_cout",      (W + 1)'(bus.cout),      (W + 1)'(0));
    @(posedge clk); #1;
    clr = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen |= bus.out_valid; end
    check("abort_no_result", (W + 1)'(seen), (W + 1)'(0));
    accept_op(128'd5, 128'd7, 1'b0);
    wait_result(lat);
    check("after_abort_sum",  (W + 1)'(bus.sum),  129'd12);
    check("after_abort_cout", (W + 1)'(bus.cout), (W + 1)'(0));
    release_result();

    // Chunk-width sweep: N=1 and N=16
    sweep(1'b1, 1,  "n1");
    sweep(1'b0, 16, "n16");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Multi-cycle sequencer for wide additions. It accepts one WIDTH-bit operand pair plus carry-in through a valid/ready handshake.
- The sum is computed CHUNK bits per cycle through one shared narrow adder, with the carry chained through a register.
- The full result and carry-out are returned through a second valid/ready handshake.
- It replaces the single-cycle 128-bit ripple add where LUT/carry-chain area matters more than latency, e.g. ahead of or behind the shift-register delay lines.

Parameters:
- WIDTH, 128, total operand/sum width in bits.
- CHUNK, 32, bits added per cycle. WIDTH % CHUNK must be 0; otherwise elaboration fails with an error.
- N (localparam), WIDTH/CHUNK, number of chunk cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair and cin valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  sum/cout valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (clr=1, asynchronous):
  - state=IDLE, chunk counter=0, carry reg=0.
  - Operand regs=0, sum reg=0, cout=0.
  - in_ready=0 while clr is asserted, then 1 in IDLE; out_valid=0; busy=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, a/b are latched into a_r/b_r and cin into the carry reg.
  - Counter is set to 0; next state is RUN.
- RUN:
  - in_ready=0.
  - Each cycle: {c, s} = a_r[k*CHUNK +: CHUNK] + b_r[k*CHUNK +: CHUNK] + carry, where k is the counter.
  - s is written to sum_r[k*CHUNK +: CHUNK]; c is written to the carry reg; counter increments.
  - When k == N-1: cout <= c and next state is DONE.
- DONE:
  - out_valid=1; sum/cout are stable.
  - When out_ready=1 on an edge, next state is IDLE.
  - in_ready stays 0 in DONE. There is no same-cycle accept, so the result and operand handshakes never overlap.
- Latency:
  - The acceptance edge is E0. out_valid rises after edge E0+N (N=4 by default).
  - Minimum issue interval is N+2 cycles (accept, N RUN cycles, one DONE cycle with out_ready=1).
- Backpressure: with out_ready=0, DONE holds indefinitely and sum/cout do not change.
- sum register update:
  - sum_r is not cleared at accept. Chunks are overwritten in order.
  - The sum port is only meaningful while out_valid=1.
- Counter:
  - Width is clog2(N), minimum 1.
  - It never wraps while in RUN. Exit occurs at N-1.
  - When N == 1, RUN lasts exactly one cycle.
- Ignored inputs: in_valid outside IDLE and out_ready outside DONE are ignored.
- Reset mid-operation: clr in RUN or DONE aborts immediately. Everything returns to reset values and the pending result is discarded.
- X-safety: a/b/cin are sampled only on the accept edge.

Decomposition:
- Shared package (adder_pkg): state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, and default WIDTH/CHUNK constants.
- Sub-module chunk_adder: combinational CHUNK-bit a + b + ci giving s and co. It is instantiated once and is the shared resource being sequenced.

Test Plan:
1. Carry ripple through all chunks: a=all-ones(128), b=0, cin=1 -> sum=0, cout=1; out_valid rises exactly 4 cycles after the accept edge.
2. Plain add: a=0x1, b=0x2, cin=0 -> sum=0x3, cout=0. Also a=0xFFFFFFFF (chunk 0 only), b=1 -> sum=0x1_00000000, checking carry into chunk 1.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> sum/cout stable, in_ready=0 and busy=1 throughout. Assert out_ready -> IDLE next cycle, in_ready=1.
4. Back-to-back: keep in_valid=1 with 3 distinct random operand pairs and out_ready=1 -> each result matches the reference a+b+cin and each is issued 6 cycles apart. No operands are accepted during RUN/DONE.
5. Reset mid-operation: assert clr at RUN cycle k=2 -> out_valid never rises for that op; outputs read reset values. The next op after release, 5+7 -> sum=12.
6. Parameter sweep: CHUNK=128 (N=1) and CHUNK=8 (N=16) with all-ones+cin=1 -> sum=0, cout=1, latency 1 and 16 cycles respectively.
